uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle data-valid pulse and queues it in a first-word-fall-through FIFO. It presents occupancy and status to the bus register block, and raises a threshold interrupt and an idle-timeout interrupt. This lets software drain bytes in bursts instead of servicing every byte.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
AW, 4, pointer width; equals log2(DEPTH)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous reset, active low
rx_byte_i  input  8  received byte from receiver
rx_dv_i  input  1  one-cycle pulse: rx_byte_i valid, push request
rd_i  input  1  pop request from register block, one cycle per byte
clr_i  input  1  synchronous flush
thresh_i  input  AW+1  interrupt threshold in bytes; 0 disables
timeout_i  input  16  idle timeout in clk cycles; 0 disables
rd_data_o  output  8  head-of-FIFO byte (FWFT); 0 when empty
count_o  output  AW+1  current occupancy, 0..DEPTH
empty_o  output  1  count_o == 0
full_o  output  1  count_o == DEPTH
overflow_o  output  1  sticky: a byte was dropped because the FIFO was full
intr_rx_o  output  1  level: thresh_i != 0 and count_o >= thresh_i
timeout_o  output  1  sticky idle-timeout flag

Behaviour:
- Reset (async, rst_ni low):
  - pointers = 0, count_o = 0, empty_o = 1, full_o = 0.
  - overflow_o = 0, timeout_o = 0, idle counter = 0.
  - rd_data_o = 0, intr_rx_o = 0.
  - Storage contents are don't-care.
- Storage: DEPTH x 8 array with wr_ptr/rd_ptr of AW bits; both pointers wrap modulo DEPTH.
- count_o is a registered AW+1-bit counter.
- Priority each cycle: clr_i > push/pop.
- clr_i = 1:
  - pointers and count go to 0; overflow_o and timeout_o clear; idle counter clears.
  - A same-cycle rx_dv_i byte is discarded and does not set overflow.
  - A same-cycle rd_i is ignored.
- Push: rx_dv_i = 1 and (not full, or full with a valid pop this cycle). Write at wr_ptr, wr_ptr+1.
- Pop: rd_i = 1 and not empty. rd_ptr+1.
- rd_i while empty is ignored: no pointer or flag change, no error flag.
- Push and pop in the same cycle:
  - Not empty: both occur, count unchanged.
  - Full: both occur, no overflow.
  - Empty: push only; the byte appears on rd_data_o next cycle.
- Overflow: rx_dv_i while full with no valid pop drops the byte; FIFO is unchanged; overflow_o <= 1 next cycle.
- overflow_o stays set until clr_i.
- FWFT: rd_data_o = mem[rd_ptr] whenever not empty, combinational from registered state.
  - A pushed byte is visible one cycle after its rx_dv_i pulse.
  - After a pop, the next entry is visible on the following cycle.
- intr_rx_o is combinational from count_o and thresh_i. thresh_i > DEPTH is permitted and never fires.
- Idle counter (16 bits):
  - Cleared on any push, any valid pop, clr_i, or while empty.
  - Otherwise increments by 1 per cycle and saturates at 0xFFFF.
  - When timeout_i != 0 and counter == timeout_i - 1 while non-empty, timeout_o <= 1 next cycle, i.e. exactly timeout_i cycles after the last push/pop.
  - timeout_o stays set until the next push, valid pop, or clr_i; each of these clears it on the following clock edge.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight rx_dv_i is lost.

Test Plan:
- Reset with rst_ni low, then release -> empty_o = 1, count_o = 0, rd_data_o = 0, all flags 0.
- Push 0xA5, 0x3C (pulses 2 cycles apart) -> count_o = 2; rd_data_o = 0xA5. Pulse rd_i -> rd_data_o = 0x3C next cycle. Pop again -> empty_o = 1.
- Push 16 bytes 0x00..0x0F -> full_o = 1. Push 0xFF -> overflow_o = 1 and count_o = 16. Drain -> 0x00..0x0F in order with wrap-around correct. clr_i -> overflow_o = 0.
- Full FIFO with rx_dv_i and rd_i in the same cycle -> count_o stays 16, overflow_o = 0, new byte read last. Empty FIFO with push+pop same cycle -> count_o = 1.
- thresh_i = 4: push 3 bytes -> intr_rx_o = 0; 4th push -> intr_rx_o = 1; one pop -> intr_rx_o = 0. thresh_i = 0 -> never asserts.
- timeout_i = 10, push 1 byte, then idle -> timeout_o = 1 exactly 10 cycles after the push edge. Pop -> timeout_o clears next cycle. clr_i asserted together with rx_dv_i -> count_o = 0, byte discarded.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through queue with
// occupancy/status outputs, a threshold interrupt and a sticky idle-timeout flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_dv_i,
    input  logic          rd_i,
    input  logic          clr_i,
    input  logic [AW:0]   thresh_i,
    input  logic [15:0]   timeout_i,
    output logic [7:0]    rd_data_o,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overflow_o,
    output logic          intr_rx_o,
    output logic          timeout_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   idle_q, idle_d;
    logic          empty, full, push, pop;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == (AW+1)'(DEPTH));
        pop        = rd_i && !empty && !clr_i;
        // A full FIFO still accepts a byte when the same cycle frees an entry.
        push       = rx_dv_i && (!full || pop) && !clr_i;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        idle_d     = idle_q;

        if (clr_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
            idle_d     = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !push) count_d = count_q - (AW+1)'(1);

            if (rx_dv_i && full && !pop) overflow_d = 1'b1;

            if (push || pop || empty)   idle_d = '0;
            else if (idle_q != 16'hFFFF) idle_d = idle_q + 16'd1;

            // Activity wins over a coincident timeout match.
            if (push || pop)
                timeout_d = 1'b0;
            else if ((timeout_i != '0) && !empty && (idle_q == timeout_i - 16'd1))
                timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            idle_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            idle_q     <= idle_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rx_byte_i;
    end

    always_comb begin
        rd_data_o  = empty ? 8'h00 : mem_q[rd_ptr_q];
        count_o    = count_q;
        empty_o    = empty;
        full_o     = full;
        overflow_o = overflow_q;
        timeout_o  = timeout_q;
        intr_rx_o  = (thresh_i != '0) && (count_q >= thresh_i);
    end

endmodule
